// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial byte receiver: FSM state encoding,
// default word width and the parity helper.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StWait
  } state_t;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned MaxDataW = 16;

  // Parity bit that makes word+parity satisfy the requested sense.
  // Callers zero-extend narrower words; extra zeros do not change parity.
  function automatic logic calc_parity(input logic [MaxDataW-1:0] word, input logic odd);
    return odd ? ~(^word) : (^word);
  endfunction

endpackage

// File: rtl/serial_rx_hold.sv
// Single-entry valid/ready holding register for recovered words.
// A commit into a full, unaccepted register is dropped and flagged as overrun.
module serial_rx_hold #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              commit,
  input  logic [DATA_W-1:0] word,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (commit) begin
      // A same-edge acceptance frees the slot for the incoming word.
      if (!valid_q || out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/serial_byte_rx.sv
// Serial frame receiver: start/data/parity/stop recovery at one bit per clock,
// with registered single-cycle framing, parity and overrun error pulses.
module serial_byte_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 1
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W:0]   shift_ext;
  logic              par_q, par_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              parity_ok;
  logic              commit;

  assign parity_ok = (PARITY_EN == 0) ||
                     (calc_parity(MaxDataW'(shift_q), PARITY_ODD != 0) == par_q);

  // Bits arrive LSB first; after DATA_W right shifts the first bit sits in bit 0.
  assign shift_ext = {in, shift_q} >> 1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!in) begin
          state_d = StData;
          cnt_d   = '0;
        end
      end
      StData: begin
        shift_d = shift_ext[DATA_W-1:0];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) begin
          state_d = (PARITY_EN != 0) ? StParity : StStop;
        end
      end
      StParity: begin
        par_d   = in;
        state_d = StStop;
      end
      StStop: begin
        if (in) begin
          state_d = StIdle;
          if (parity_ok) begin
            commit = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  serial_rx_hold #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk      (clk),
    .areset   (areset),
    .commit   (commit),
    .word     (shift_q),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .overrun  (overrun)
  );

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed and randomized bench for serial_byte_rx (DATA_W=8, odd parity) against a
// frame-level reference model of the holding register and error pulses.
module tb_serial_byte_rx;

  logic       clk;
  logic       areset;
  logic       in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  int checks;
  int failures;

  // Reference model: content of the word-level output stage.
  logic       m_valid;
  logic [7:0] m_data;

  serial_byte_rx #(
    .DATA_W    (8),
    .PARITY_EN (1),
    .PARITY_ODD(1)
  ) dut (
    .clk       (clk),
    .areset    (areset),
    .in        (in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line bit per clock; model updated from frame-level facts, then outputs compared.
  task automatic step(input logic b, input logic rdy, input logic exp_busy, input logic exp_fe,
                      input logic stop_ok, input logic [7:0] word, input logic par_good);
    logic exp_pe;
    logic exp_ov;
    exp_pe = 1'b0;
    exp_ov = 1'b0;
    @(negedge clk);
    in        = b;
    out_ready = rdy;
    @(posedge clk);
    #1;
    if (stop_ok) begin
      if (!par_good) exp_pe = 1'b1;
      else if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = word;
      end else exp_ov = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    chk("out_valid", 16'(out_valid), 16'(m_valid));
    if (m_valid) chk("out_data", 16'(out_data), 16'(m_data));
    chk("busy", 16'(busy), 16'(exp_busy));
    chk("frame_err", 16'(frame_err), 16'(exp_fe));
    chk("parity_err", 16'(parity_err), 16'(exp_pe));
    chk("overrun", 16'(overrun), 16'(exp_ov));
  endtask

  // mode: 0 never ready, 1 always ready, 2 random, 3 ready only on the stop bit
  function automatic logic pick_rdy(input int mode, input logic is_stop);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return is_stop;
    endcase
  endfunction

  task automatic idle(input logic rdy);
    step(1'b1, rdy, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] word, input logic flip_par, input logic stop_bit,
                            input int mode);
    logic par;
    logic good;
    par  = ((($countones(word) % 2) == 0) ? 1'b1 : 1'b0) ^ flip_par;
    good = ((($countones(word) + int'(par)) % 2) == 1);
    step(1'b0, pick_rdy(mode, 1'b0), 1'b1, 1'b0, 1'b0, word, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(word[i], pick_rdy(mode, 1'b0), 1'b1, 1'b0, 1'b0, word, 1'b1);
    end
    step(par, pick_rdy(mode, 1'b0), 1'b1, 1'b0, 1'b0, word, 1'b1);
    if (stop_bit) step(1'b1, pick_rdy(mode, 1'b1), 1'b0, 1'b0, 1'b1, word, good);
    else step(1'b0, pick_rdy(mode, 1'b1), 1'b1, 1'b1, 1'b0, word, 1'b1);
  endtask

  task automatic wait_line(input int zeros, input logic rdy);
    for (int i = 0; i < zeros; i++) begin
      step(1'b0, rdy, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    end
    idle(rdy);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    areset    = 1'b0;
    in        = 1'b1;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_errs", 16'({frame_err, parity_err, overrun}), 16'h0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;
    idle(1'b0);

    // Clean frame, consumer ready
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    idle(1'b1);
    // Bad parity
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    idle(1'b1);
    // Bad stop bit, line held low for three cycles
    send_frame(8'hA5, 1'b0, 1'b0, 1);
    wait_line(3, 1'b1);
    idle(1'b1);
    // Back-to-back frames with no consumer: overrun on the second
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 0);
    idle(1'b1);
    idle(1'b0);
    // Acceptance and new commit on the same edge
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 3);
    idle(1'b1);

    // Asynchronous reset in the middle of the data bits
    idle(1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    #2;
    areset = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    chk("midrst_out_valid", 16'(out_valid), 16'h0);
    chk("midrst_out_data", 16'(out_data), 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_errs", 16'({frame_err, parity_err, overrun}), 16'h0);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;
    idle(1'b0);
    send_frame(8'h01, 1'b0, 1'b1, 1);
    idle(1'b1);

    // Randomized frames, gaps, errors and consumer behaviour
    for (int f = 0; f < 40; f++) begin
      logic [7:0] w;
      logic       flip;
      logic       stop_b;
      w      = 8'($urandom);
      flip   = ($urandom_range(0, 3) == 0);
      stop_b = ($urandom_range(0, 7) != 0);
      send_frame(w, flip, stop_b, 2);
      if (!stop_b) wait_line(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(1'($urandom_range(0, 1)));
    end
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
